param_deser_rx: RTL and testbench
=================================

PARAM_DESER_RX -- requirements
Module: param_deser_rx

Interface
REQ-001 Parameter DATA_MAX, default 8: maximum frame data bits, legal range 5..16.
REQ-002 Parameter PRE_W, default 6: width of the prescale and edge-counter buses.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with the ports listed in REQ-004 and REQ-005.
REQ-004 CLK_pdes  in  1  rising-edge clock, the receiver oversampling clock.
REQ-005 RST_pdes  in  1  asynchronous active-low reset.
REQ-006 sample_bit  in  1  majority-voted data bit from the sampler.
REQ-007 deser_en  in  1  data-phase enable from the RX FSM.
REQ-008 edge_cnt  in  PRE_W  current oversampling edge count.
REQ-009 prescale  in  PRE_W  oversampling ratio.
REQ-010 data_len  in  5  requested data bits per frame.
REQ-011 msb_first  in  1  bit-order select: 0 = LSB first (UART), 1 = MSB first.
REQ-012 P_DATA  out  DATA_MAX  last completed word, right-aligned, with unused upper bits = 0.
REQ-013 data_vld  out  1  single-cycle pulse when P_DATA updates.
REQ-014 par_calc  out  1  XOR of the data bits of the last completed word.
REQ-015 bit_cnt  out  5  number of bits captured in the current frame.
REQ-016 busy  out  1  high when bit_cnt is not 0.

Function
REQ-017 The capture strobe SHALL be deser_en=1 AND prescale not equal to 0 AND edge_cnt equal to prescale-1, computed in PRE_W bits; prescale=0 SHALL never strobe.
REQ-018 The frame length SHALL be clamped and latched on the first strobe of a frame (bit_cnt=0): data_len<5 gives 5, data_len>DATA_MAX gives DATA_MAX; data_len changes mid-frame SHALL be ignored.
REQ-019 The frame bit order SHALL be latched with the length on the first strobe; msb_first changes mid-frame SHALL be ignored.
REQ-020 On each strobe the internal shift register SHALL take one bit: LSB-first shifts right with the new bit inserted at bit [DATA_MAX-1]; MSB-first shifts left with the new bit inserted at bit [0].
REQ-021 On each strobe bit_cnt SHALL increment and the running parity SHALL XOR in sample_bit.
REQ-022 On the strobe that brings bit_cnt to the latched length L, the next cycle SHALL show all of the following:
  - P_DATA equals the completed word, right-aligned (LSB-first: shift register shifted right by DATA_MAX-L);
  - par_calc equals the running parity including the final bit;
  - data_vld equals 1 for exactly one cycle;
  - bit_cnt, the shift register and the running parity return to 0.
REQ-023 P_DATA and par_calc SHALL hold their value until the next completed frame or reset; a partial frame SHALL never alter them.
REQ-024 If deser_en falls while bit_cnt is not 0, the frame SHALL abort on the next clock: bit_cnt, the shift register and the running parity clear, data_vld stays 0, and P_DATA and par_calc are unchanged.
REQ-025 Strobes on consecutive clock cycles SHALL all be accepted, giving a one-bit-per-cycle capture rate.
REQ-026 A strobe in the cycle directly after completion SHALL start a new frame with bit_cnt=1.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-028 While RST_pdes=0 the following SHALL be 0, independent of the clock: P_DATA, par_calc, data_vld, bit_cnt, busy, the shift register, the running parity and the latched length/order.
REQ-029 A reset asserted mid-frame SHALL discard the partial frame, and no data_vld SHALL follow the release of reset.

Verification
REQ-030 Case 1, LSB-first: prescale=8, data_len=8, msb_first=0, bits 1,0,1,0,0,1,0,1 strobed at edge_cnt=7 -> P_DATA=0xA5, par_calc=0, data_vld pulses once.
REQ-031 Case 2, MSB-first: data_len=5, msb_first=1, bits 1,0,0,1,1 -> P_DATA=0x13, par_calc=1.
REQ-032 Case 3, clamping: data_len=3 -> frame completes after 5 bits; data_len=20 with DATA_MAX=8 -> frame completes after 8 bits.
REQ-033 Case 4, abort: deser_en dropped after 4 bits -> bit_cnt=0 next cycle, P_DATA holds its prior value, no data_vld; the next full frame completes correctly.
REQ-034 Case 5, strobe gating: prescale=0 with deser_en=1 and edge_cnt cycling -> bit_cnt stays 0; prescale=32 -> strobes occur only at edge_cnt=31.
REQ-035 Case 6, reset mid-frame: RST_pdes pulsed low after 6 bits -> all outputs 0 asynchronously; no data_vld after release; a 6-bit frame after release gives the correct word.

Source files
------------

// File: rtl/param_deser_rx.sv
// Deserialiser for the oversampling receiver: captures one voted bit per strobe, supports
// LSB/MSB-first framing with a clamped, per-frame latched length, and reports word plus parity.
module param_deser_rx #(
  parameter int unsigned DATA_MAX = 8,
  parameter int unsigned PRE_W    = 6
) (
  input  logic                CLK_pdes,
  input  logic                RST_pdes,
  input  logic                sample_bit,
  input  logic                deser_en,
  input  logic [PRE_W-1:0]    edge_cnt,
  input  logic [PRE_W-1:0]    prescale,
  input  logic [4:0]          data_len,
  input  logic                msb_first,
  output logic [DATA_MAX-1:0] P_DATA,
  output logic                data_vld,
  output logic                par_calc,
  output logic [4:0]          bit_cnt,
  output logic                busy
);

  localparam logic [4:0] DataMax5 = 5'(DATA_MAX);
  localparam logic [4:0] DataMin5 = 5'd5;

  logic [DATA_MAX-1:0] shift_q, shift_d, shift_new;
  logic [DATA_MAX-1:0] p_data_q, p_data_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d, cnt_inc;
  logic [4:0]          len_q, len_d, len_clamped, cur_len;
  logic                msb_q, msb_d, cur_msb;
  logic                par_run_q, par_run_d, par_next;
  logic                par_calc_q, par_calc_d;
  logic                data_vld_q, data_vld_d;
  logic                busy_q;
  logic                strobe;

  // prescale - 1 wraps in PRE_W bits, so prescale = 0 must be excluded explicitly
  assign strobe = deser_en && (prescale != '0) && (edge_cnt == (prescale - PRE_W'(1)));

  always_comb begin
    len_clamped = data_len;
    if (data_len < DataMin5) begin
      len_clamped = DataMin5;
    end else if (data_len > DataMax5) begin
      len_clamped = DataMax5;
    end
  end

  // Length and order come from the inputs only on the first bit of a frame
  assign cur_len   = (bit_cnt_q == 5'd0) ? len_clamped : len_q;
  assign cur_msb   = (bit_cnt_q == 5'd0) ? msb_first : msb_q;
  assign shift_new = cur_msb ? {shift_q[DATA_MAX-2:0], sample_bit}
                             : {sample_bit, shift_q[DATA_MAX-1:1]};
  assign cnt_inc   = bit_cnt_q + 5'd1;
  assign par_next  = par_run_q ^ sample_bit;

  always_comb begin
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    bit_cnt_d  = bit_cnt_q;
    len_d      = len_q;
    msb_d      = msb_q;
    par_run_d  = par_run_q;
    par_calc_d = par_calc_q;
    data_vld_d = 1'b0;
    if (!deser_en && (bit_cnt_q != 5'd0)) begin
      shift_d   = '0;
      bit_cnt_d = 5'd0;
      par_run_d = 1'b0;
    end else if (strobe) begin
      len_d = cur_len;
      msb_d = cur_msb;
      if (cnt_inc == cur_len) begin
        // LSB-first words sit at the top of the register and must be right-aligned
        p_data_d   = cur_msb ? shift_new : (shift_new >> (DataMax5 - cur_len));
        par_calc_d = par_next;
        data_vld_d = 1'b1;
        shift_d    = '0;
        bit_cnt_d  = 5'd0;
        par_run_d  = 1'b0;
      end else begin
        shift_d   = shift_new;
        bit_cnt_d = cnt_inc;
        par_run_d = par_next;
      end
    end
  end

  always_ff @(posedge CLK_pdes or negedge RST_pdes) begin
    if (!RST_pdes) begin
      shift_q    <= '0;
      p_data_q   <= '0;
      bit_cnt_q  <= 5'd0;
      len_q      <= 5'd0;
      msb_q      <= 1'b0;
      par_run_q  <= 1'b0;
      par_calc_q <= 1'b0;
      data_vld_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      bit_cnt_q  <= bit_cnt_d;
      len_q      <= len_d;
      msb_q      <= msb_d;
      par_run_q  <= par_run_d;
      par_calc_q <= par_calc_d;
      data_vld_q <= data_vld_d;
      busy_q     <= (bit_cnt_d != 5'd0);
    end
  end

  assign P_DATA   = p_data_q;
  assign data_vld = data_vld_q;
  assign par_calc = par_calc_q;
  assign bit_cnt  = bit_cnt_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_param_deser_rx.sv
// Bench for param_deser_rx: directed vector table, hand-built corner sequences and a
// randomised run checked against a queue-based frame model.
module tb_param_deser_rx;
  localparam int DM = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sb = 1'b0;
  logic          de = 1'b0;
  logic [PW-1:0] ec = '0;
  logic [PW-1:0] ps = '0;
  logic [4:0]    dl = 5'd8;
  logic          msb = 1'b0;
  logic [DM-1:0] p_data;
  logic          vld;
  logic          par;
  logic [4:0]    cnt;
  logic          busy;

  param_deser_rx #(.DATA_MAX(DM), .PRE_W(PW)) dut (
    .CLK_pdes  (clk),
    .RST_pdes  (rst_n),
    .sample_bit(sb),
    .deser_en  (de),
    .edge_cnt  (ec),
    .prescale  (ps),
    .data_len  (dl),
    .msb_first (msb),
    .P_DATA    (p_data),
    .data_vld  (vld),
    .par_calc  (par),
    .bit_cnt   (cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: bits of the open frame plus the last completed word
  int q[$];
  int m_len = 0;
  int m_msb = 0;
  int m_pdata = 0;
  int m_par = 0;
  int m_vld = 0;

  typedef struct {
    logic          de;
    logic [PW-1:0] ec;
    logic [PW-1:0] ps;
    logic [4:0]    dl;
    logic          msb;
    logic          sb;
    logic [4:0]    e_cnt;
    logic          e_vld;
    logic [DM-1:0] e_pdata;
    logic          e_par;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_len = 0;
    m_msb = 0;
    m_pdata = 0;
    m_par = 0;
    m_vld = 0;
  endtask

  task automatic model_step();
    int w;
    int p;
    m_vld = 0;
    if (!de && q.size() != 0) begin
      q.delete();
    end else if (de && ps != 0 && int'(ec) == int'(ps) - 1) begin
      if (q.size() == 0) begin
        m_len = (dl < 5) ? 5 : ((int'(dl) > DM) ? DM : int'(dl));
        m_msb = int'(msb);
      end
      q.push_back(int'(sb));
      if (q.size() == m_len) begin
        w = 0;
        p = 0;
        for (int i = 0; i < m_len; i++) begin
          if (m_msb != 0) w += q[i] << (m_len - 1 - i);
          else            w += q[i] << i;
          p ^= q[i];
        end
        m_pdata = w;
        m_par = p;
        m_vld = 1;
        q.delete();
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".P_DATA"}, 32'(p_data), 32'(m_pdata));
    chk({tag, ".par_calc"}, 32'(par), 32'(m_par));
    chk({tag, ".data_vld"}, 32'(vld), 32'(m_vld));
    chk({tag, ".bit_cnt"}, 32'(cnt), 32'(q.size()));
    chk({tag, ".busy"}, 32'(busy), 32'(q.size() != 0));
  endtask

  task automatic set_in(input logic i_de, input logic [PW-1:0] i_ec, input logic [PW-1:0] i_ps,
                        input logic [4:0] i_dl, input logic i_msb, input logic i_sb);
    de = i_de;
    ec = i_ec;
    ps = i_ps;
    dl = i_dl;
    msb = i_msb;
    sb = i_sb;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  function automatic vec_t mk(input logic v_de, input int v_ec, input int v_ps, input int v_dl,
                              input logic v_msb, input logic v_sb, input int v_cnt,
                              input logic v_vld, input int v_pd, input logic v_par);
    vec_t v;
    v.de = v_de;
    v.ec = PW'(v_ec);
    v.ps = PW'(v_ps);
    v.dl = 5'(v_dl);
    v.msb = v_msb;
    v.sb = v_sb;
    v.e_cnt = 5'(v_cnt);
    v.e_vld = v_vld;
    v.e_pdata = DM'(v_pd);
    v.e_par = v_par;
    return v;
  endfunction

  // Drives n strobes (prescale 1 => strobe every cycle) from the given bit pattern, LSB of pat first
  task automatic strobes(input string tag, input int n, input int pat, input int len,
                         input logic order);
    for (int i = 0; i < n; i++) begin
      set_in(1'b1, '0, PW'(1), 5'(len), order, 1'(pat >> i));
      cycle(tag);
    end
  endtask

  initial begin
    logic [PW-1:0] ps_pool[7];
    ps_pool = '{PW'(0), PW'(1), PW'(2), PW'(3), PW'(8), PW'(32), PW'(63)};

    // Gating: near-miss edge count, prescale 0 whose wrapped prescale-1 would match
    vecs.push_back(mk(1, 6, 8, 8, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 63, 0, 8, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 0, 8, 0, 1, 0, 0, 8'h00, 0));
    // LSB-first 0xA5
    vecs.push_back(mk(1, 7, 8, 8, 0, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(1, 7, 8, 8, 0, 0, 2, 0, 8'h00, 0));
    vecs.push_back(mk(1, 7, 8, 8, 0, 1, 3, 0, 8'h00, 0));
    vecs.push_back(mk(1, 7, 8, 8, 0, 0, 4, 0, 8'h00, 0));
    vecs.push_back(mk(1, 7, 8, 8, 0, 0, 5, 0, 8'h00, 0));
    vecs.push_back(mk(1, 7, 8, 8, 0, 1, 6, 0, 8'h00, 0));
    vecs.push_back(mk(1, 7, 8, 8, 0, 0, 7, 0, 8'h00, 0));
    vecs.push_back(mk(1, 7, 8, 8, 0, 1, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, 0, 8, 8, 0, 0, 0, 0, 8'hA5, 0));
    // MSB-first 0x13; length/order changes after the first bit must be ignored
    vecs.push_back(mk(1, 7, 8, 5, 1, 1, 1, 0, 8'hA5, 0));
    vecs.push_back(mk(1, 7, 8, 20, 0, 0, 2, 0, 8'hA5, 0));
    vecs.push_back(mk(1, 7, 8, 20, 0, 0, 3, 0, 8'hA5, 0));
    vecs.push_back(mk(1, 7, 8, 20, 0, 1, 4, 0, 8'hA5, 0));
    vecs.push_back(mk(1, 7, 8, 20, 0, 1, 0, 1, 8'h13, 1));
    // prescale 32: strobe only at edge_cnt 31; data_len 3 clamps to 5
    vecs.push_back(mk(1, 30, 32, 3, 0, 1, 0, 0, 8'h13, 1));
    vecs.push_back(mk(1, 31, 32, 3, 0, 1, 1, 0, 8'h13, 1));
    vecs.push_back(mk(1, 31, 32, 3, 0, 1, 2, 0, 8'h13, 1));
    vecs.push_back(mk(1, 0, 32, 3, 0, 0, 2, 0, 8'h13, 1));
    vecs.push_back(mk(1, 31, 32, 3, 0, 1, 3, 0, 8'h13, 1));
    vecs.push_back(mk(1, 31, 32, 3, 0, 1, 4, 0, 8'h13, 1));
    vecs.push_back(mk(1, 31, 32, 3, 0, 1, 0, 1, 8'h1F, 1));

    #2;
    chk("reset.P_DATA", 32'(p_data), 32'h0);
    chk("reset.par_calc", 32'(par), 32'h0);
    chk("reset.data_vld", 32'(vld), 32'h0);
    chk("reset.bit_cnt", 32'(cnt), 32'h0);
    chk("reset.busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    foreach (vecs[i]) begin
      set_in(vecs[i].de, vecs[i].ec, vecs[i].ps, vecs[i].dl, vecs[i].msb, vecs[i].sb);
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_cnt", i), 32'(cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d.tbl_vld", i), 32'(vld), 32'(vecs[i].e_vld));
      chk($sformatf("vec%0d.tbl_pdata", i), 32'(p_data), 32'(vecs[i].e_pdata));
      chk($sformatf("vec%0d.tbl_par", i), 32'(par), 32'(vecs[i].e_par));
    end

    // Clamp high: data_len 20 gives 8 bits, back-to-back strobes; bits 0,1,1,0,1,0,0,0
    strobes("clamp20", 7, 8'h16, 20, 1'b0);
    chk("clamp20.cnt7", 32'(cnt), 32'd7);
    strobes("clamp20", 1, 8'h16 >> 7, 20, 1'b0);
    chk("clamp20.vld", 32'(vld), 32'd1);
    chk("clamp20.pdata", 32'(p_data), 32'h16);
    chk("clamp20.par", 32'(par), 32'd1);

    // Abort after 4 bits, then a full frame
    strobes("abort", 4, 4'hF, 8, 1'b0);
    set_in(1'b0, '0, PW'(1), 5'd8, 1'b0, 1'b1);
    cycle("abort");
    chk("abort.cnt", 32'(cnt), 32'd0);
    chk("abort.vld", 32'(vld), 32'd0);
    chk("abort.pdata", 32'(p_data), 32'h16);
    strobes("after_abort", 8, 8'h3C, 8, 1'b0);
    chk("after_abort.pdata", 32'(p_data), 32'h3C);
    chk("after_abort.vld", 32'(vld), 32'd1);

    // Reset after 6 bits: outputs clear without a clock edge
    strobes("rst_mid", 6, 6'h2A, 8, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.P_DATA", 32'(p_data), 32'h0);
    chk("rst_mid.bit_cnt", 32'(cnt), 32'h0);
    chk("rst_mid.busy", 32'(busy), 32'h0);
    chk("rst_mid.par_calc", 32'(par), 32'h0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, '0, PW'(1), 5'd6, 1'b0, 1'b0);
      cycle("post_rst");
    end
    strobes("post_rst6", 6, 6'h2D, 6, 1'b0);
    chk("post_rst6.pdata", 32'(p_data), 32'h2D);
    chk("post_rst6.par", 32'(par), 32'd0);
    chk("post_rst6.vld", 32'(vld), 32'd1);

    // prescale 0 with edge count sweeping never strobes
    for (int i = 0; i < 70; i++) begin
      set_in(1'b1, PW'(i), '0, 5'd8, 1'b0, 1'b1);
      cycle("ps0");
    end
    chk("ps0.cnt", 32'(cnt), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      logic [PW-1:0] p;
      p = ps_pool[$urandom_range(0, 6)];
      set_in(($urandom_range(0, 19) != 0), ($urandom_range(0, 2) != 0) ? PW'(p - 1'b1)
                                                                      : PW'($urandom_range(0, 63)),
             p, ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : dl,
             ($urandom_range(0, 7) == 0) ? ~msb : msb, 1'($urandom));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
